// File: rtl/noc_pe_interface_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pe_interface_pkg
// Description : Shared NoC definitions. Contains the coordinate and field widths,
//               the field offsets (measured from the packet MSB), the packet
//               header struct, and the handshake FSM state encodings used by
//               the PE interface, switch and arbiter blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pe_interface_pkg;

    localparam int c_coord_w = 2;                  // bits per X or Y coordinate
    localparam int c_node_w  = 2 * c_coord_w;      // {X,Y} node address
    localparam int c_hdr_w   = 1 + 2 * c_node_w;   // reserved + dest + source

    // Field positions expressed as distance of the field's top bit from the MSB
    localparam int c_rsvd_top_off    = 0;
    localparam int c_dest_top_off    = 1;
    localparam int c_src_top_off     = 1 + c_node_w;
    localparam int c_payload_top_off = c_hdr_w;

    // Header occupies the top c_hdr_w bits; payload fills the remainder
    typedef struct packed {
        logic                rsvd;
        logic [c_node_w-1:0] dest;
        logic [c_node_w-1:0] src;
    } noc_hdr_t;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_REQ  = 2'd1,
        TX_REL  = 2'd2
    } tx_state_t;

    typedef enum logic [0:0] {
        RX_WAIT = 1'b0,
        RX_ACK  = 1'b1
    } rx_state_t;

    function automatic int payload_width(input int width);
        return width - c_hdr_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/noc_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : noc_sync_fifo
// Description : Synchronous first-word-fall-through FIFO. The head entry is
//               always visible on pop_data (zero when empty). A push into a
//               full FIFO is ignored even if a pop occurs in the same cycle.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               push, push_data - write request and data
//               full            - no free entry
//               pop             - consume head this cycle
//               pop_data, empty - head entry and empty flag
// Revision    : 1.0 - initial release
// ============================================================================
module noc_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    // Extra MSB on each pointer distinguishes full from empty
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);

    // Full is judged on the pre-pop state, so push-while-full never lands
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    assign pop_data = empty ? '0 : r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; the pointers define which entries are valid
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/noc_pe_interface.sv
`default_nettype none
// ============================================================================
// Module      : noc_pe_interface
// Description : Bridges a synchronous PE valid/ready interface to the router's
//               asynchronous 4-phase bundled-data handshake in both directions.
//               TX stamps the local source address onto outgoing packets; RX
//               buffers incoming packets in a FWFT FIFO and back-pressures the
//               router by withholding acknowledge while the FIFO is full.
// Ports       : clk, rst_n                     - clock, async active-low reset
//               tx_valid/tx_ready/tx_dest/tx_payload - PE transmit side
//               net_req_out/net_ack_in/net_data_out  - 4-phase link to router
//               net_req_in/net_ack_out/net_data_in   - 4-phase link from router
//               rx_valid/rx_ready/rx_data            - PE receive side
// Revision    : 1.0 - initial release
// ============================================================================
module noc_pe_interface
    import noc_pe_interface_pkg::*;
#(
    parameter int                   WIDTH    = 33,
    parameter logic [c_coord_w-1:0] ADDR_X   = 2'b00,
    parameter logic [c_coord_w-1:0] ADDR_Y   = 2'b00,
    parameter int                   RX_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    input  logic [c_node_w-1:0]    tx_dest,
    input  logic [WIDTH-10:0]      tx_payload,
    output logic                   net_req_out,
    input  logic                   net_ack_in,
    output logic [WIDTH-1:0]       net_data_out,
    input  logic                   net_req_in,
    output logic                   net_ack_out,
    input  logic [WIDTH-1:0]       net_data_in,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic [WIDTH-1:0]       rx_data
);

    localparam int c_payload_w = payload_width(WIDTH);

    // ------------------------------------------------------------------
    // Two-flop synchronizers for the asynchronous handshake inputs
    // ------------------------------------------------------------------
    logic [1:0] r_ack_sync;
    logic [1:0] r_req_sync;
    logic       w_ack_s;
    logic       w_req_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack_sync <= 2'b00;
            r_req_sync <= 2'b00;
        end else begin
            r_ack_sync <= {r_ack_sync[0], net_ack_in};
            r_req_sync <= {r_req_sync[0], net_req_in};
        end
    end

    assign w_ack_s = r_ack_sync[1];
    assign w_req_s = r_req_sync[1];

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    tx_state_t                r_tx_state;
    logic                     r_net_req;
    logic [WIDTH-1:0]         r_net_data;
    noc_hdr_t                 w_tx_hdr;
    logic [WIDTH-1:0]         w_tx_packet;
    logic [c_payload_w-1:0]   w_tx_payload;

    assign w_tx_payload = tx_payload;
    assign w_tx_hdr     = '{rsvd: 1'b0, dest: tx_dest, src: {ADDR_X, ADDR_Y}};
    assign w_tx_packet  = {w_tx_hdr, w_tx_payload};

    // Held low while in reset so the PE never sees a ready during reset
    assign tx_ready     = rst_n && (r_tx_state == TX_IDLE);
    assign net_req_out  = r_net_req;
    assign net_data_out = r_net_data;

    // net_data_out is only loaded in TX_IDLE, so it stays stable for the
    // whole request/release sequence. Local destinations go to the router too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
            r_net_req  <= 1'b0;
            r_net_data <= '0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (tx_valid) begin
                        r_net_data <= w_tx_packet;
                        r_net_req  <= 1'b1;
                        r_tx_state <= TX_REQ;
                    end
                end
                TX_REQ: begin
                    if (w_ack_s) begin
                        r_net_req  <= 1'b0;
                        r_tx_state <= TX_REL;
                    end
                end
                TX_REL: begin
                    if (!w_ack_s) r_tx_state <= TX_IDLE;
                end
                default: begin
                    r_net_req  <= 1'b0;
                    r_tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    rx_state_t r_rx_state;
    logic      r_net_ack;
    logic      w_fifo_full;
    logic      w_fifo_empty;
    logic      w_rx_push;

    // Exactly one write per request: only RX_WAIT may push, and it leaves
    // RX_WAIT on the same edge. A full FIFO simply delays the acknowledge.
    assign w_rx_push   = (r_rx_state == RX_WAIT) && w_req_s && !w_fifo_full;
    assign net_ack_out = r_net_ack;
    assign rx_valid    = !w_fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= RX_WAIT;
            r_net_ack  <= 1'b0;
        end else begin
            case (r_rx_state)
                RX_WAIT: begin
                    if (w_rx_push) begin
                        r_net_ack  <= 1'b1;
                        r_rx_state <= RX_ACK;
                    end
                end
                RX_ACK: begin
                    if (!w_req_s) begin
                        r_net_ack  <= 1'b0;
                        r_rx_state <= RX_WAIT;
                    end
                end
                default: begin
                    r_net_ack  <= 1'b0;
                    r_rx_state <= RX_WAIT;
                end
            endcase
        end
    end

    noc_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_rx_push),
        .push_data (net_data_in),
        .full      (w_fifo_full),
        .pop       (rx_ready),
        .pop_data  (rx_data),
        .empty     (w_fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_noc_pe_interface.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_pe_interface
// Description : Scoreboard bench for noc_pe_interface (node address X=1, Y=2).
//               Stimulus threads push expected packets into queues; monitors
//               pop and compare when the DUT presents a packet to the router
//               (net_req_out rise) or to the PE (rx_valid && rx_ready).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_pe_interface;

    localparam int W = 33;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tx_valid = 1'b0;
    logic         tx_ready;
    logic [3:0]   tx_dest = 4'h0;
    logic [23:0]  tx_payload = 24'h0;
    logic         net_req_out;
    logic         net_ack_in = 1'b0;
    logic [W-1:0] net_data_out;
    logic         net_req_in = 1'b0;
    logic         net_ack_out;
    logic [W-1:0] net_data_in = '0;
    logic         rx_valid;
    logic         rx_ready = 1'b0;
    logic [W-1:0] rx_data;

    int checks = 0;
    int errors = 0;
    int ack_dly = 3;

    logic [W-1:0] tx_exp[$];
    logic [W-1:0] rx_exp[$];

    logic         txm_prev = 1'b0;
    logic         txm_busy = 1'b0;
    logic [W-1:0] txm_held = '0;

    always #5 clk = ~clk;

    noc_pe_interface #(
        .WIDTH    (W),
        .ADDR_X   (2'b01),
        .ADDR_Y   (2'b10),
        .RX_DEPTH (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_dest      (tx_dest),
        .tx_payload   (tx_payload),
        .net_req_out  (net_req_out),
        .net_ack_in   (net_ack_in),
        .net_data_out (net_data_out),
        .net_req_in   (net_req_in),
        .net_ack_out  (net_ack_out),
        .net_data_in  (net_data_in),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting, expected event within bound", name);
    endtask

    // Expected outgoing packet for this node (source {01,10} = 4'h6)
    function automatic logic [W-1:0] mk_pkt(input logic [3:0] d, input logic [23:0] p);
        return {1'b0, d, 4'h6, p};
    endfunction

    // Router-side acknowledge responder with a programmable delay
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                net_ack_in = 1'b0;
                cnt = 0;
            end else if (net_req_out !== net_ack_in) begin
                if (cnt >= ack_dly) begin
                    net_ack_in = net_req_out;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // TX monitor: compare on request rise, then check data stays put until idle
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                txm_prev = 1'b0;
                txm_busy = 1'b0;
            end else begin
                if (net_req_out && !txm_prev) begin
                    if (tx_exp.size() == 0) timeout_fail("tx_unexpected_packet");
                    else check("tx_pkt", net_data_out, tx_exp.pop_front());
                    txm_held = net_data_out;
                    txm_busy = 1'b1;
                end else if (txm_busy) begin
                    if (tx_ready) txm_busy = 1'b0;
                    else check("tx_hold", net_data_out, txm_held);
                end
                txm_prev = net_req_out;
            end
        end
    end

    // RX monitor: every accepted pop must match the oldest outstanding packet
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && rx_valid && rx_ready) begin
                if (rx_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_extra: got %h expected no packet", rx_data);
                end else begin
                    check("rx_pkt", rx_data, rx_exp.pop_front());
                end
            end
        end
    end

    task automatic tx_send(input logic [3:0] d, input logic [23:0] p);
        int n;
        n = 0;
        @(negedge clk);
        while (!tx_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            timeout_fail("tx_ready_wait");
        end else begin
            tx_exp.push_back(mk_pkt(d, p));
            tx_dest    = d;
            tx_payload = p;
            tx_valid   = 1'b1;
            @(posedge clk);
            #1 tx_valid = 1'b0;
        end
    endtask

    task automatic router_send(input logic [W-1:0] d, input int dly);
        int n;
        repeat (dly) @(posedge clk);
        #1;
        rx_exp.push_back(d);
        net_data_in = d;
        net_req_in  = 1'b1;
        n = 0;
        while (!net_ack_out && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!net_ack_out) begin
            timeout_fail("rx_ack_rise");
            net_req_in = 1'b0;
            return;
        end
        repeat (dly) @(posedge clk);
        #1 net_req_in = 1'b0;
        n = 0;
        while (net_ack_out && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (net_ack_out) timeout_fail("rx_ack_fall");
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((rx_exp.size() != 0 || tx_exp.size() != 0 || !tx_ready || net_ack_out) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) timeout_fail(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] pk [5];
        logic [3:0]   dl [6];
        int n;

        // ---------------- reset state ----------------
        #1;
        check1("rst_req_out", net_req_out, 1'b0);
        check1("rst_ack_out", net_ack_out, 1'b0);
        check("rst_data_out", net_data_out, '0);
        check1("rst_rx_valid", rx_valid, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check1("tx_ready_after_rst", tx_ready, 1'b1);

        // ---------------- single TX with ack delay 3 ----------------
        ack_dly = 3;
        tx_send(4'b0011, 24'h0ABCDE);
        check1("tx_ready_busy", tx_ready, 1'b0);
        check1("tx_req_high", net_req_out, 1'b1);
        check("tx_literal", net_data_out, 33'h0_360A_BCDE);
        check("f_rsvd", {32'd0, net_data_out[32]}, 33'd0);
        check("f_dest", {29'd0, net_data_out[31:28]}, 33'd3);
        check("f_src", {29'd0, net_data_out[27:24]}, 33'd6);
        check("f_payload", {9'd0, net_data_out[23:0]}, 33'h0ABCDE);
        n = 0;
        while (!net_ack_in && n < 100) begin @(negedge clk); n++; end
        if (!net_ack_in) timeout_fail("tx_ack_rise");
        else check1("req_until_synced_ack", net_req_out, 1'b1);
        n = 0;
        while (!tx_ready && n < 100) begin @(negedge clk); n++; end
        if (!tx_ready) timeout_fail("tx_ready_return");
        else check1("ack_low_at_ready", net_ack_in, 1'b0);

        // ---------------- RX back-pressure, depth 2 ----------------
        rx_ready = 1'b0;
        fork
            begin
                router_send(33'h0_1111_1111, 0);
                router_send(33'h0_2222_2222, 0);
                router_send(33'h0_3333_3333, 0);
            end
            begin
                repeat (60) @(posedge clk);
                #1;
                check1("bp_req_held", net_req_in, 1'b1);
                check1("bp_no_ack", net_ack_out, 1'b0);
                check1("bp_rx_valid", rx_valid, 1'b1);
                check("bp_head", rx_data, 33'h0_1111_1111);
                check_int("bp_outstanding", rx_exp.size(), 3);
                rx_ready = 1'b1;
            end
        join
        drain("drain_bp");

        // ---------------- 5 back-to-back RX packets ----------------
        pk[0] = 33'h0_0000_0001; pk[1] = 33'h0_FFFF_FFFF; pk[2] = 33'h0_A5A5_5A5A;
        pk[3] = 33'h0_1234_5678; pk[4] = 33'h0_8000_0000;
        rx_ready = 1'b1;
        for (int i = 0; i < 5; i++) router_send(pk[i], 0);
        drain("drain_b2b");

        // ---------------- concurrent TX/RX, random delays ----------------
        dl[0] = 4'b0000; dl[1] = 4'b0110; dl[2] = 4'b1111;
        dl[3] = 4'b1001; dl[4] = 4'b0101; dl[5] = 4'b1010;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    ack_dly = $urandom_range(0, 7);
                    tx_send(dl[i], 24'h100000 + 24'(i * 24'h01F3));
                end
            end
            begin
                for (int i = 0; i < 6; i++)
                    router_send({1'b0, 8'hC0 + 8'(i), 24'hDEAD00 + 24'(i)}, $urandom_range(0, 7));
            end
            begin
                repeat (300) begin
                    @(posedge clk);
                    #1 rx_ready = 1'($urandom_range(0, 1));
                end
                rx_ready = 1'b1;
            end
        join
        drain("drain_concurrent");

        // ---------------- reset in TX_REQ and RX_ACK ----------------
        rx_ready = 1'b0;
        ack_dly  = 50;
        fork
            tx_send(4'b1001, 24'h123456);
            begin
                @(posedge clk);
                #1 net_data_in = 33'h0_9655_00AA;
                net_req_in = 1'b1;
            end
        join
        n = 0;
        while (!(net_ack_out && net_req_out) && n < 100) begin @(negedge clk); n++; end
        check1("pre_rst_req_out", net_req_out, 1'b1);
        check1("pre_rst_ack_out", net_ack_out, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check1("mid_rst_req_out", net_req_out, 1'b0);
        check1("mid_rst_ack_out", net_ack_out, 1'b0);
        check("mid_rst_data_out", net_data_out, '0);
        check1("mid_rst_rx_valid", rx_valid, 1'b0);
        check("mid_rst_rx_data", rx_data, '0);
        check1("mid_rst_tx_ready", tx_ready, 1'b0);
        net_req_in = 1'b0;
        tx_valid   = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        ack_dly = 2;
        #1;
        check1("post_rst_tx_ready", tx_ready, 1'b1);
        check1("post_rst_rx_valid", rx_valid, 1'b0);
        rx_ready = 1'b1;
        fork
            tx_send(4'b1100, 24'hC0FFEE);
            router_send(33'h0_C600_BEEF, 1);
        join
        drain("drain_post_rst");

        check_int("tx_queue_empty", tx_exp.size(), 0);
        check_int("rx_queue_empty", rx_exp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/noc_pe_interface.md
NOC_PE_INTERFACE -- requirements
Module: noc_pe_interface

Interface
REQ-001 SHALL have parameter WIDTH, default 33, meaning packet width in bits.
REQ-002 SHALL have parameter ADDR_X, default 2'b00, meaning this node's X address, stamped as source X.
REQ-003 SHALL have parameter ADDR_Y, default 2'b00, meaning this node's Y address, stamped as source Y.
REQ-004 SHALL have parameter RX_DEPTH, default 2, meaning receive FIFO entries (power of two, >=2).
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port tx_valid, input, 1, meaning PE offers a packet.
REQ-008 SHALL have port tx_ready, output, 1, meaning the interface accepts tx_dest/tx_payload this cycle.
REQ-009 SHALL have port tx_dest, input, 4, meaning {dest X[1:0], dest Y[1:0]}.
REQ-010 SHALL have port tx_payload, input, WIDTH-9, meaning PE payload bits.
REQ-011 SHALL have port net_req_out, output, 1, meaning 4-phase request toward router PE input.
REQ-012 SHALL have port net_ack_in, input, 1, meaning asynchronous 4-phase acknowledge from router.
REQ-013 SHALL have port net_data_out, output, WIDTH, meaning bundled packet toward router.
REQ-014 SHALL have port net_req_in, input, 1, meaning asynchronous 4-phase request from router PE output.
REQ-015 SHALL have port net_ack_out, output, 1, meaning 4-phase acknowledge toward router.
REQ-016 SHALL have port net_data_in, input, WIDTH, meaning bundled packet from router, stable while net_req_in high.
REQ-017 SHALL have port rx_valid, output, 1, meaning FIFO head packet available to PE.
REQ-018 SHALL have port rx_ready, input, 1, meaning PE consumes head this cycle when rx_valid.
REQ-019 SHALL have port rx_data, output, WIDTH, meaning FIFO head packet.

Function
REQ-020 Packet format SHALL be [WIDTH-1]=1'b0 reserved, [WIDTH-2:WIDTH-5]=dest {X,Y}, [WIDTH-6:WIDTH-9]=source {X,Y}, [WIDTH-10:0]=payload.
REQ-021 net_ack_in and net_req_in SHALL each pass a two-flop synchronizer before any use; 2-cycle synchronizer latency counts in all timings below.
REQ-022 TX FSM SHALL have states TX_IDLE, TX_REQ (net_req_out=1, wait synced ack=1), TX_REL (net_req_out=0, wait synced ack=0).
REQ-023 tx_ready SHALL be 1 only in TX_IDLE; handshake completes when tx_valid&&tx_ready; packet (with ADDR_X/ADDR_Y stamped) is registered into net_data_out and FSM enters TX_REQ next edge.
REQ-024 net_data_out SHALL be registered and unchanged from net_req_out rise until synced ack is observed low in TX_REL.
REQ-025 TX_REQ->TX_REL on synced ack=1; TX_REL->TX_IDLE on synced ack=0; no new packet accepted before return to TX_IDLE.
REQ-026 RX FSM SHALL have states RX_WAIT (net_ack_out=0) and RX_ACK (net_ack_out=1).
REQ-027 In RX_WAIT, when synced req=1 and FIFO not full, net_data_in SHALL be written to FIFO and state goes RX_ACK same edge; if FIFO full, state stays RX_WAIT (back-pressure, no drop).
REQ-028 RX_ACK->RX_WAIT on synced req=0; no second write per request.
REQ-029 FIFO SHALL be first-word-fall-through: rx_data shows head, rx_valid=!empty, pop on rx_valid&&rx_ready.
REQ-030 Simultaneous push and pop when full SHALL NOT be allowed to push (full evaluated before pop); simultaneous push/pop otherwise SHALL keep count unchanged.
REQ-031 FIFO pointers SHALL wrap modulo RX_DEPTH with one extra bit for full/empty discrimination.
REQ-032 TX and RX paths SHALL operate independently and concurrently.
REQ-033 Local-destination packets (dest==own address) SHALL still be sent to the router; no internal loopback.

Reset
REQ-034 On rst_n low, asynchronously: TX_IDLE, RX_WAIT, net_req_out=0, net_ack_out=0, net_data_out=0, synchronizers=0, FIFO empty (rx_valid=0), tx_ready=1 once rst_n high.
REQ-035 Reset mid-handshake SHALL abandon the transaction; router side is required to be reset concurrently.

Structure
REQ-036 Packet field offsets, field widths and the packet struct/typedef SHALL live in the shared NoC package used by switch and arbiter blocks.
REQ-037 Receive FIFO SHALL be one sub-module, noc_sync_fifo, parameterized by WIDTH and DEPTH.

Verification
REQ-038 ADDR=(1,2), tx_dest=4'b0011, payload=24'hABCDE, responder ack after 3 cycles -> net_data_out=33'h0_3_6_0ABCDE fields correct, net_req_out high until synced ack, tx_ready returns after ack low.
REQ-039 Router sends 3 packets with rx_ready=0, RX_DEPTH=2 -> 2 acked, third held with net_ack_out=0 until one pop, then acked; order preserved.
REQ-040 rx_ready=1 constantly, 5 back-to-back router packets -> rx_data sequence identical to input, no duplicates.
REQ-041 Concurrent TX and RX traffic with random ack/req delays 0-7 cycles -> scoreboard matches both directions.
REQ-042 rst_n pulled low while in TX_REQ and RX_ACK -> all outputs 0 immediately, FIFO empty, normal transfer works after release.
